// File: rtl/bk_serial_add_ctrl_if.sv
// Operand/result handshake bundle for bk_serial_add_ctrl.
// Port sub exists only when BK_SERIAL_SUB_EN is defined.
interface bk_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1. A source holds its payload stable until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
`ifdef BK_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic [1:0]       state_dbg;

  modport slave (
    input  in_valid, op_a, op_b, cin,
`ifdef BK_SERIAL_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy, state_dbg
  );

  modport master (
    output in_valid, op_a, op_b, cin,
`ifdef BK_SERIAL_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy, state_dbg
  );
endinterface

// File: rtl/bk_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder around one 4-bit Brent-Kung cell, LSB nibble first.
// Optional subtract mode is enabled by defining BK_SERIAL_SUB_EN.
module bk_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  bk_serial_add_ctrl_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("bk_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       b_eff;
  logic [4:0]       add_out;
  logic             accept;
  logic             last;
`ifdef BK_SERIAL_SUB_EN
  logic             sub_r;
`endif

  // 4-bit Brent-Kung prefix adder with carry-in: {cout, sum}.
  function automatic logic [4:0] brent_kung_cin(input logic [3:0] a,
                                                input logic [3:0] b,
                                                input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic       g10, p10, g32, p32, g30, p30;
    logic [4:0] c;
    g   = a & b;
    p   = a ^ b;
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g10 | (p10 & ci);
    c[3] = g[2] | (p[2] & c[2]);
    c[4] = g30 | (p30 & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign accept = bus.in_valid & (state == IDLE);
  assign last   = (idx == IDXW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last)         state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Combinational nibble select feeding the shared adder cell.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int k = 0; k < NIB; k++) begin
      if (idx == IDXW'(k)) begin
        nib_a = opa_r[4*k +: 4];
        nib_b = opb_r[4*k +: 4];
      end
    end
  end

`ifdef BK_SERIAL_SUB_EN
  assign b_eff = sub_r ? ~nib_b : nib_b;
`else
  assign b_eff = nib_b;
`endif

  assign add_out = brent_kung_cin(nib_a, b_eff, carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      opa_r  <= '0;
      opb_r  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
`ifdef BK_SERIAL_SUB_EN
      sub_r  <= 1'b0;
`endif
    end else if (accept) begin
      opa_r <= bus.op_a;
      opb_r <= bus.op_b;
      idx   <= '0;
`ifdef BK_SERIAL_SUB_EN
      // Subtraction is a + ~b + 1, so the external carry is replaced by 1.
      sub_r <= bus.sub;
      carry <= bus.sub ? 1'b1 : bus.cin;
`else
      carry <= bus.cin;
`endif
    end else if (state == RUN) begin
      for (int k = 0; k < NIB; k++) begin
        if (idx == IDXW'(k)) sum_r[4*k +: 4] <= add_out[3:0];
      end
      carry <= add_out[4];
      if (last) begin
        cout_r <= add_out[4];
        idx    <= '0;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.state_dbg = state;
endmodule
